// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, PC source and exception cause codes
// for the multicycle PC sequencer.
package pc_seq_pkg;

  localparam logic [2:0] RESET_S  = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] DECODE   = 3'd2;
  localparam logic [2:0] EXEC     = 3'd3;
  localparam logic [2:0] EXC_SAVE = 3'd4;
  localparam logic [2:0] EXC_JUMP = 3'd5;
  localparam logic [2:0] HALT     = 3'd6;

  localparam logic [1:0] PCSRC_PC4    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EPC    = 2'b11;

  localparam logic [1:0] EXC_ILLEGAL = 2'b00;
  localparam logic [1:0] EXC_OVF     = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       epcwrite;
    logic       irwrite;
    logic       memread;
    logic       epcsub;
    logic       excsel;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pc_seq_timeout.sv
// pc_seq_timeout: 8-bit saturating fetch wait counter; hit when the
// count equals LIMIT, first while the count is still zero.
module pc_seq_timeout
  import pc_seq_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit,
  output logic first
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != 8'hff) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign hit   = (cnt == LIMIT[7:0]);
  assign first = (cnt == 8'd0);

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multicycle fetch/decode/exec sequencer driving the PC path.
// Optional PC_SEQ_RETIRE_CNT_EN adds a 32-bit retired-instruction count.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_ready,
  input  logic        is_branch,
  input  logic        branch_ne,
  input  logic        is_jump,
  input  logic        is_eret,
  input  logic        illegal_op,
  input  logic        alu_zero,
  input  logic        overflow,
  input  logic        halt_req,
  output logic [1:0]  PCSrc,
  output logic        PCWrite,
  output logic        EPCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        EpcSub,
  output logic        ExcSel,
  output logic [1:0]  ExcCause,
`ifdef PC_SEQ_RETIRE_CNT_EN
  output logic [31:0] retired,
`endif
  output logic        halted
);

  logic [2:0] state;
  logic [2:0] nxt;
  logic [1:0] cause;
  logic [1:0] cause_nxt;
  ctrl_t      ctl;
  logic       in_fetch;
  logic       to_hit;
  logic       fetch_first;

  assign in_fetch = (state == FETCH);

  pc_seq_timeout #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_fetch),
    .en    (in_fetch && !mem_ready),
    .hit   (to_hit),
    .first (fetch_first)
  );

  always_comb begin
    nxt       = state;
    cause_nxt = cause;
    ctl       = CTRL_IDLE;
    unique case (state)
      RESET_S: nxt = FETCH;
      FETCH: begin
        // halt is only honoured on the first FETCH cycle
        if (fetch_first && halt_req) begin
          nxt = HALT;
        end else begin
          ctl.memread = 1'b1;
          if (mem_ready) begin
            ctl.irwrite = 1'b1;
            ctl.pcsrc   = PCSRC_PC4;
            ctl.pcwrite = 1'b1;
            nxt         = DECODE;
          end else if (to_hit) begin
            cause_nxt = EXC_TIMEOUT;
            nxt       = EXC_SAVE;
          end
        end
      end
      DECODE: begin
        if (illegal_op) begin
          cause_nxt = EXC_ILLEGAL;
          nxt       = EXC_SAVE;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        nxt = FETCH;
        if (overflow) begin
          cause_nxt = EXC_OVF;
          nxt       = EXC_SAVE;
        end else if (is_eret) begin
          ctl.pcsrc   = PCSRC_EPC;
          ctl.pcwrite = 1'b1;
        end else if (is_jump) begin
          ctl.pcsrc   = PCSRC_JUMP;
          ctl.pcwrite = 1'b1;
        end else if (is_branch) begin
          ctl.pcsrc   = PCSRC_ALUOUT;
          ctl.pcwrite = alu_zero ^ branch_ne;
        end
      end
      EXC_SAVE: begin
        ctl.epcsub   = 1'b1;
        ctl.epcwrite = 1'b1;
        ctl.excsel   = 1'b1;
        nxt          = EXC_JUMP;
      end
      EXC_JUMP: begin
        ctl.pcsrc   = PCSRC_ALUOUT;
        ctl.pcwrite = 1'b1;
        ctl.excsel  = 1'b1;
        nxt         = FETCH;
      end
      HALT: nxt = HALT;
      default: nxt = RESET_S;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_S;
      cause <= EXC_ILLEGAL;
    end else begin
      state <= nxt;
      cause <= cause_nxt;
    end
  end

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic [31:0] ret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_q <= '0;
    end else if (state == EXEC && nxt == FETCH) begin
      ret_q <= ret_q + 32'd1;
    end
  end

  assign retired = ret_q;
`endif

  assign PCSrc    = ctl.pcsrc;
  assign PCWrite  = ctl.pcwrite;
  assign EPCWrite = ctl.epcwrite;
  assign IRWrite  = ctl.irwrite;
  assign MemRead  = ctl.memread;
  assign EpcSub   = ctl.epcsub;
  assign ExcSel   = ctl.excsel;
  assign ExcCause = cause;
  assign halted   = (state == HALT);

endmodule
